// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: same-cycle hit path, whole-block refill on a miss.
// Holds 2**INDEX_W blocks of four 32-bit words, tagged by PC[ADDR_W-1:INDEX_W+4].
module icache #(
  parameter int ADDR_W  = 10,
  parameter int INDEX_W = 3
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         PC,
  output logic [31:0]         INSTRUCTION,
  output logic                BUSYWAIT,
  output logic                MEM_READ,
  output logic [ADDR_W-5:0]   MEM_ADDRESS,
  input  logic [127:0]        MEM_READDATA,
  input  logic                MEM_BUSYWAIT
);

  localparam int TAG_W = ADDR_W - INDEX_W - 4;
  localparam int NBLK  = 1 << INDEX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t              state_r;
  logic [NBLK-1:0]     valid_r;
  logic [TAG_W-1:0]    tag_r  [NBLK];
  logic [127:0]        data_r [NBLK];
  logic [ADDR_W-5:0]   req_addr_r;
  logic [127:0]        line_buf_r;

  logic [TAG_W-1:0]    pc_tag_s;
  logic [INDEX_W-1:0]  pc_idx_s;
  logic [1:0]          pc_off_s;
  logic [INDEX_W-1:0]  req_idx_s;
  logic [TAG_W-1:0]    req_tag_s;
  logic                hit_s;
  logic                busy_s;
  logic                rd_s;
  logic                unused_pc_s;

  assign pc_tag_s    = PC[ADDR_W-1:INDEX_W+4];
  assign pc_idx_s    = PC[INDEX_W+3:4];
  assign pc_off_s    = PC[3:2];
  assign req_idx_s   = req_addr_r[INDEX_W-1:0];
  assign req_tag_s   = req_addr_r[ADDR_W-5:INDEX_W];
  assign unused_pc_s = ^{PC[31:ADDR_W], PC[1:0]};

  assign hit_s       = valid_r[pc_idx_s] && (tag_r[pc_idx_s] == pc_tag_s);
  assign INSTRUCTION = data_r[pc_idx_s][{pc_off_s, 5'd0} +: 32];
  assign BUSYWAIT    = busy_s;
  assign MEM_READ    = rd_s;
  // The request address is held after the fill; it is only meaningful while MEM_READ is high.
  assign MEM_ADDRESS = req_addr_r;

  // Stall and memory-request decode; reset forces both low so the cpu is never held in reset.
  always_comb begin
    busy_s = 1'b0;
    rd_s   = 1'b0;
    if (RESET) begin
      busy_s = 1'b0;
      rd_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          busy_s = ~hit_s;
          rd_s   = 1'b0;
        end
        FETCH: begin
          busy_s = 1'b1;
          rd_s   = 1'b1;
        end
        UPDATE: begin
          busy_s = 1'b1;
          rd_s   = 1'b0;
        end
        default: begin
          busy_s = 1'b0;
          rd_s   = 1'b0;
        end
      endcase
    end
  end

  // Miss-handling controller: latch the missing block, wait for memory, then install it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r    <= IDLE;
      valid_r    <= '0;
      req_addr_r <= '0;
      line_buf_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!hit_s) begin
            req_addr_r <= {pc_tag_s, pc_idx_s};
            state_r    <= FETCH;
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            line_buf_r <= MEM_READDATA;
            state_r    <= UPDATE;
          end
        end
        UPDATE: begin
          valid_r[req_idx_s] <= 1'b1;
          state_r            <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Tag and data storage need no reset; a block is only trusted once its valid bit is set.
  always_ff @(posedge CLK) begin
    if (!RESET && (state_r == UPDATE)) begin
      data_r[req_idx_s] <= line_buf_r;
      tag_r[req_idx_s]  <= req_tag_s;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache: a memory model with programmable latency, a cache-contents
// reference model checked every cycle, and directed scenarios with hand-computed expectations.
module tb_icache;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  PC;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA;
  logic         MEM_BUSYWAIT = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int lat      = 5;
  int mem_cnt  = 0;

  // reference model: which memory block each index currently holds
  logic [7:0]  mv = 8'h00;
  logic [5:0]  mb [8];
  bit          in_miss = 1'b0;
  int          age = 0;
  int          miss_lat = 0;
  logic [5:0]  miss_blk = 6'd0;

  icache #(.ADDR_W(10), .INDEX_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] k);
    return (32'(k) * 32'h11111111) ^ {2'b00, blk, 24'h000000};
  endfunction

  assign MEM_READDATA = {mem_word(MEM_ADDRESS, 2'd3), mem_word(MEM_ADDRESS, 2'd2),
                         mem_word(MEM_ADDRESS, 2'd1), mem_word(MEM_ADDRESS, 2'd0)};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // instruction memory: busy for `lat` cycles of each read, data valid when busy drops
  always @(negedge CLK) begin
    if (MEM_READ && (mem_cnt < lat)) begin
      MEM_BUSYWAIT = 1'b1;
      mem_cnt++;
    end else begin
      MEM_BUSYWAIT = 1'b0;
      if (!MEM_READ) mem_cnt = 0;
    end
  end

  // per-cycle comparison against the model: a miss at cycle c reads memory in c+1..c+lat+1,
  // stalls one more cycle, and the block is resident from c+lat+3
  always @(negedge CLK) begin : cmp
    logic [5:0] blk;
    logic       hit;
    if (RESET) begin
      check("reset_busywait", {31'd0, BUSYWAIT}, 32'd0);
      check("reset_mem_read", {31'd0, MEM_READ}, 32'd0);
      mv      = 8'h00;
      in_miss = 1'b0;
    end else if (!in_miss) begin
      blk = PC[9:4];
      hit = mv[blk[2:0]] && (mb[blk[2:0]] == blk);
      check("busywait", {31'd0, BUSYWAIT}, {31'd0, ~hit});
      check("mem_read_idle", {31'd0, MEM_READ}, 32'd0);
      if (hit) check("instruction", INSTRUCTION, mem_word(blk, PC[3:2]));
      else begin
        in_miss  = 1'b1;
        age      = 0;
        miss_blk = blk;
        miss_lat = lat;
      end
    end else begin
      age++;
      check("busywait_miss", {31'd0, BUSYWAIT}, 32'd1);
      check("mem_read_miss", {31'd0, MEM_READ}, {31'd0, age <= miss_lat + 1});
      if (age <= miss_lat + 1) check("mem_address", {26'd0, MEM_ADDRESS}, {26'd0, miss_blk});
      if (age == miss_lat + 2) begin
        mv[miss_blk[2:0]] = 1'b1;
        mb[miss_blk[2:0]] = miss_blk;
        in_miss = 1'b0;
      end
    end
  end

  // PC is already applied; counts stall cycles after the miss cycle and memory-read cycles
  task automatic run_fill(output int after, output int rd, output logic [5:0] addr);
    after = 0;
    rd    = 0;
    addr  = 6'd0;
    @(negedge CLK);
    check("miss_detect", {31'd0, BUSYWAIT}, 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (!BUSYWAIT) break;
      after++;
      if (MEM_READ) begin
        rd++;
        addr = MEM_ADDRESS;
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int         after;
    int         rd;
    logic [5:0] addr;
    logic       prev_bw;
    RESET = 1'b1;
    PC    = 32'd0;
    lat   = 5;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // cold miss with a 5-cycle memory
    PC = 32'h0;
    run_fill(after, rd, addr);
    check("cold_stall_cycles", after, 32'd7);
    check("cold_read_cycles", rd, 32'd6);
    check("cold_mem_address", {26'd0, addr}, 32'd0);
    check("cold_instr", INSTRUCTION, 32'h00000000);
    check("cold_ready", {31'd0, BUSYWAIT}, 32'd0);
    @(posedge CLK); #1;

    // rest of the block hits
    for (int k = 1; k < 4; k++) begin
      PC = 32'(4 * k);
      @(negedge CLK);
      check("block_hit_busy", {31'd0, BUSYWAIT}, 32'd0);
      check("block_hit_read", {31'd0, MEM_READ}, 32'd0);
      check("block_hit_instr", INSTRUCTION, 32'(k) * 32'h11111111);
      @(posedge CLK); #1;
    end

    // conflict on index 0
    PC = 32'h80;
    run_fill(after, rd, addr);
    check("conflict_addr", {26'd0, addr}, 32'h08);
    check("conflict_instr", INSTRUCTION, 32'h08000000);
    @(posedge CLK); #1;
    PC = 32'h0;
    run_fill(after, rd, addr);
    check("refill_addr", {26'd0, addr}, 32'h00);
    @(posedge CLK); #1;

    // reset in the second fetch cycle aborts the fill
    PC = 32'h10;
    @(negedge CLK);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("fetch1_read", {31'd0, MEM_READ}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("abort_read", {31'd0, MEM_READ}, 32'd0);
    check("abort_busy", {31'd0, BUSYWAIT}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    PC = 32'h0;
    run_fill(after, rd, addr);
    check("post_reset_miss_stall", after, 32'd7);
    @(posedge CLK); #1;

    // aliasing and zero-latency memory
    PC = 32'h404;
    @(negedge CLK);
    check("alias_hit", {31'd0, BUSYWAIT}, 32'd0);
    check("alias_instr", INSTRUCTION, 32'h11111111);
    @(posedge CLK); #1;
    lat = 0;
    PC = 32'h20;
    run_fill(after, rd, addr);
    check("zero_lat_stall", after, 32'd2);
    check("zero_lat_read", rd, 32'd1);
    @(posedge CLK); #1;

    // random traffic; PC and latency only change while not stalled
    prev_bw = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLK);
      prev_bw = BUSYWAIT;
      @(posedge CLK); #1;
      RESET = ($urandom_range(0, 59) == 0);
      if (!prev_bw) begin
        PC  = {22'($urandom), 1'($urandom_range(0, 1)), 2'd0, 2'($urandom_range(0, 3)),
               3'($urandom_range(0, 7)), 2'($urandom)};
        lat = $urandom_range(0, 3);
      end
    end
    RESET = 1'b0;
    @(negedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
